// File: rtl/ml_ahb_slave_arb.sv
// ml_ahb_slave_arb: per-slave-port arbiter of the AHB multilayer matrix.
// Shares one slave port between NUM_MST master layers with a registered one-hot
// grant that only moves on completed transfers (i_hready_in=1). Round-robin
// scheduling, locked-transfer support and data-phase owner tracking.
// Optional feature macro: ML_AHB_ARB_BURST_HOLD_EN lets the current owner keep
// the port for up to HOLD_MAX consecutive transfers under contention.
module ml_ahb_slave_arb #(
   parameter int NUM_MST  = 4,
   parameter int IDX_W    = 2,
   parameter int HOLD_MAX = 4
) (
   input  logic               i_hclk,
   input  logic               i_resetn,
   input  logic [NUM_MST-1:0] i_req,
   input  logic [NUM_MST-1:0] i_lock,
   input  logic               i_hready_in,
   output logic [NUM_MST-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic [NUM_MST-1:0] o_data_owner,
   output logic               o_busy
);

   typedef enum logic [1:0] {
      ST_PARK   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             r_state;
   logic [NUM_MST-1:0] r_grant;
   logic [IDX_W-1:0]   r_grant_idx;
   logic [NUM_MST-1:0] r_data_owner;

   logic               w_other_found;
   logic [IDX_W-1:0]   w_other_idx;
   logic [IDX_W:0]     w_sum;
   logic               w_own_req;
   logic               w_own_lock;
   logic               w_may_rotate;
   logic               w_move;
   state_t             w_next_state;

   assign w_own_req  = i_req[r_grant_idx];
   assign w_own_lock = w_own_req & i_lock[r_grant_idx];

`ifdef ML_AHB_ARB_BURST_HOLD_EN
   localparam int HOLD_W = ($clog2(HOLD_MAX) < 2) ? 2 : $clog2(HOLD_MAX);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

   logic [HOLD_W-1:0] r_hold_cnt;

   // The owner may only be displaced once it stops requesting or has used its hold quota.
   assign w_may_rotate = ~w_own_req | (r_hold_cnt >= HOLD_LAST);

   // Count consecutive completed owner transfers; cleared whenever the grant moves or the port parks.
   always_ff @(posedge i_hclk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_hold_cnt <= '0;
      end else if (i_hready_in) begin
         if (w_move || (w_next_state == ST_PARK)) begin
            r_hold_cnt <= '0;
         end else if (w_own_req && (r_hold_cnt != HOLD_LAST)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end
      end
   end
`else
   assign w_may_rotate = 1'b1;
`endif

   // Round-robin search of the other layers, starting at owner+1 and wrapping; owner excluded.
   always_comb begin
      w_other_found = 1'b0;
      w_other_idx   = r_grant_idx;
      w_sum         = '0;
      for (int i = 1; i < NUM_MST; i++) begin
         w_sum = {1'b0, r_grant_idx} + (IDX_W+1)'(i);
         if (w_sum >= (IDX_W+1)'(NUM_MST)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_MST);
         end
         if (!w_other_found && i_req[w_sum[IDX_W-1:0]]) begin
            w_other_found = 1'b1;
            w_other_idx   = w_sum[IDX_W-1:0];
         end
      end
   end

   // Arbitration decision for the next completed cycle: whether the grant moves and where the FSM goes.
   always_comb begin
      w_move       = 1'b0;
      w_next_state = r_state;
      case (r_state)
         ST_PARK: begin
            if (w_other_found) begin
               w_move       = 1'b1;
               w_next_state = ST_ACTIVE;
            end else if (w_own_req) begin
               w_next_state = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (w_own_lock) begin
               w_next_state = ST_LOCKED;
            end else if (w_other_found && w_may_rotate) begin
               w_move = 1'b1;
            end else if (!w_own_req) begin
               w_next_state = ST_PARK;
            end
         end
         ST_LOCKED: begin
            if (!w_own_lock) begin
               w_next_state = ST_ACTIVE;
               w_move       = w_other_found & w_may_rotate;
            end
         end
         default: begin
            w_next_state = ST_PARK;
         end
      endcase
   end

   // Arbiter FSM with registered one-hot grant and its index; everything frozen during wait states.
   always_ff @(posedge i_hclk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state     <= ST_PARK;
         r_grant     <= NUM_MST'(1);
         r_grant_idx <= '0;
      end else if (i_hready_in) begin
         r_state <= w_next_state;
         if (w_move) begin
            r_grant     <= NUM_MST'(1) << w_other_idx;
            r_grant_idx <= w_other_idx;
         end
      end
   end

   // The layer whose address phase just completed owns the following data phase.
   always_ff @(posedge i_hclk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_data_owner <= '0;
      end else if (i_hready_in) begin
         r_data_owner <= r_grant & i_req;
      end
   end

   assign o_grant      = r_grant;
   assign o_grant_idx  = r_grant_idx;
   assign o_data_owner = r_data_owner;
   assign o_busy       = |r_data_owner;

endmodule

// File: tb/tb_ml_ahb_slave_arb.sv
// Directed testbench for ml_ahb_slave_arb (NUM_MST=4). The default build covers
// reset, round-robin, wait states, locking and parking; with
// ML_AHB_ARB_BURST_HOLD_EN defined it covers the burst-hold rotation instead.
module tb_ml_ahb_slave_arb;

   logic       clock;
   logic       resetN;
   logic [3:0] req;
   logic [3:0] lock;
   logic       hreadyIn;
   logic [3:0] grant;
   logic [1:0] grantIdx;
   logic [3:0] dataOwner;
   logic       busy;

   int compared   = 0;
   int mismatched = 0;

   ml_ahb_slave_arb #(
      .NUM_MST (4),
      .IDX_W   (2),
      .HOLD_MAX(4)
   ) dut (
      .i_hclk      (clock),
      .i_resetn    (resetN),
      .i_req       (req),
      .i_lock      (lock),
      .i_hready_in (hreadyIn),
      .o_grant     (grant),
      .o_grant_idx (grantIdx),
      .o_data_owner(dataOwner),
      .o_busy      (busy)
   );

   // Free-running 100 MHz clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle of inputs just after an edge, then wait until just after the next edge.
   task automatic applyStimulus(input logic [3:0] reqV, input logic [3:0] lockV, input logic hrdyV);
      req      = reqV;
      lock     = lockV;
      hreadyIn = hrdyV;
      @(posedge clock);
      #1;
   endtask

   // Compare all outputs against hand-computed expectations.
   task automatic checkOutput(input string tag, input logic [3:0] expGrant, input logic [1:0] expIdx,
                              input logic [3:0] expOwner, input logic expBusy);
      compared++;
      assert (grant === expGrant) else begin
         mismatched++;
         $error("[TB] FAIL %s grant: observed %b expected %b", tag, grant, expGrant);
      end
      compared++;
      assert (grantIdx === expIdx) else begin
         mismatched++;
         $error("[TB] FAIL %s grant_idx: observed %0d expected %0d", tag, grantIdx, expIdx);
      end
      compared++;
      assert (dataOwner === expOwner) else begin
         mismatched++;
         $error("[TB] FAIL %s data_owner: observed %b expected %b", tag, dataOwner, expOwner);
      end
      compared++;
      assert (busy === expBusy) else begin
         mismatched++;
         $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, expBusy);
      end
   endtask

   // Linear sequence of directed steps.
   initial begin
      logic [3:0] expG;
      resetN   = 1'b0;
      req      = 4'b0000;
      lock     = 4'b0000;
      hreadyIn = 1'b1;
      #12;
      checkOutput("reset", 4'b0001, 2'd0, 4'b0000, 1'b0);
      @(posedge clock);
      #1;
      resetN = 1'b1;

`ifndef ML_AHB_ARB_BURST_HOLD_EN
      $display("[TB] round-robin with all layers requesting");
      // From PARK on layer 0 the owner is tested last, so layer 1 wins first.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b1111, 4'b0000, 1'b1);
         checkOutput("rr", 4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4), 4'b0001 << (k % 4), 1'b1);
      end

      $display("[TB] wait states freeze grant and data owner");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(4'b0110, 4'b0000, 1'b0);
         checkOutput("wait_freeze", 4'b0010, 2'd1, 4'b0001, 1'b1);
      end
      applyStimulus(4'b0110, 4'b0000, 1'b1);
      checkOutput("wait_release", 4'b0100, 2'd2, 4'b0010, 1'b1);

      $display("[TB] locked transfers hold the grant");
      // Lock on non-owner layer 0 must be ignored.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b1101, 4'b0101, 1'b1);
         checkOutput("lock_hold", 4'b0100, 2'd2, 4'b0100, 1'b1);
      end
      applyStimulus(4'b1101, 4'b0000, 1'b1);
      checkOutput("lock_drop", 4'b1000, 2'd3, 4'b0100, 1'b1);

      $display("[TB] parking on the last owner");
      applyStimulus(4'b0010, 4'b0000, 1'b1);
      checkOutput("park_move", 4'b0010, 2'd1, 4'b0000, 1'b0);
      applyStimulus(4'b0010, 4'b0000, 1'b1);
      checkOutput("park_own", 4'b0010, 2'd1, 4'b0010, 1'b1);
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("park_last_data", 4'b0010, 2'd1, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("park_idle", 4'b0010, 2'd1, 4'b0000, 1'b0);
      applyStimulus(4'b0010, 4'b0000, 1'b1);
      checkOutput("park_regrant", 4'b0010, 2'd1, 4'b0010, 1'b1);
`else
      $display("[TB] burst hold rotation between layers 0 and 1");
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      checkOutput("hold_start", 4'b0001, 2'd0, 4'b0001, 1'b1);
      // Grant after step s: layer 0 for s=1..2, layer 1 for 3..6, layer 0 for 7..10, layer 1 at 11.
      for (int s = 1; s <= 11; s++) begin
         applyStimulus(4'b0011, 4'b0000, 1'b1);
         expG = ((((s + 1) / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
         checkOutput("hold_rot", expG, (expG == 4'b0001) ? 2'd0 : 2'd1,
                     ((((s) / 4) % 2) == 0) ? 4'b0001 : 4'b0010, 1'b1);
      end
`endif

      $display("[TB] asynchronous reset in the middle of traffic");
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      #3;
      resetN = 1'b0;
      #1;
      checkOutput("reset_async", 4'b0001, 2'd0, 4'b0000, 1'b0);
      @(posedge clock);
      #1;
      checkOutput("reset_held", 4'b0001, 2'd0, 4'b0000, 1'b0);
      resetN = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
